// File: rtl/uart_tx_core.sv
// ============================================================================
// uart_tx_core
// ----------------------------------------------------------------------------
// Byte-serialising UART transmitter. Sits directly downstream of the PID
// frame buffer. Each accepted tx_start sends one byte on the serial line as:
//
//   start bit (0) | 8 data bits, LSB first | optional parity | 1 or 2 stop (1)
//
// The frame buffer paces its 7-byte frames on tx_busy. It waits for busy to
// drop and then issues the next start.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit, >= 2 (434 = 50 MHz / 115200)
//   PARITY       : 0 = none, 1 = even, 2 = odd
//   STOP_BITS    : 1 or 2
//
// Ports
//   clk       in   system clock; all logic on the rising edge
//   rst_n     in   asynchronous active-low reset; aborts any frame in flight
//   tx_data   in   [7:0] byte to send; sampled only when a start is accepted
//   tx_start  in   single-cycle send request; ignored unless idle
//   tx        out  serial line; idles high
//   tx_busy   out  high from the cycle after acceptance to the end of the
//                  last stop bit
//   tx_done   out  one-cycle pulse on the edge that ends the last stop bit
//
// Every output is a flop, so there is no combinational path from the inputs
// to tx, tx_busy or tx_done.
// ============================================================================
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // The bit-clock counter runs 0..CLKS_PER_BIT-1, so $clog2 bits is enough.
    // The guard keeps the width legal if the parameter is ever mis-set to 1.
    localparam int              CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit              HAS_PARITY = (PARITY != 0);
    localparam bit              TWO_STOP   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Parity of the byte as it will appear on the line.
    // Even parity: the parity bit makes the total number of ones even, so it
    // is the XOR of the byte. Odd parity is the inverse of that.
    // ------------------------------------------------------------------------
    function automatic logic calc_parity(input logic [7:0] data_byte);
        logic p;
        p = ^data_byte;
        if (PARITY == 2) begin
            p = ~p;
        end
        return p;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;    // cycles elapsed inside the current bit
    logic [2:0]       bit_idx;    // data bit currently on the line
    logic             stop_cnt;   // second stop bit in progress (2-stop mode)
    logic [7:0]       shreg;      // byte being sent; bit 0 is the next data bit
    logic             par_bit;    // parity of the latched byte

    logic             bit_end;    // last cycle of the current bit period
    logic             accept;     // start request taken this cycle

    assign bit_end = (bit_cnt == CNT_LAST);
    assign accept  = (state == ST_IDLE) && tx_start;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // Each state loads tx with the value of the *next* bit on the edge that
    // ends the current one, so the line changes exactly on bit boundaries
    // with no decode stage between the state register and the pin.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // The bit clock is held at zero while idle so that
                    // START gets a full CLKS_PER_BIT cycles.
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= 1'b0;
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                    if (tx_start) begin
                        state   <= ST_START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PARITY) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // shreg shifts on this same edge, so the bit
                            // that follows is shreg[1] before the shift.
                            tx <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (TWO_STOP && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            // A tx_start on this edge sees ST_STOP and is
                            // dropped; the first IDLE cycle follows.
                            stop_cnt <= 1'b0;
                            state    <= ST_IDLE;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                    stop_cnt <= 1'b0;
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Data path: byte and parity latch plus shifter. These carry no reset;
    // the FSM never reads them before an accept has loaded them. Loading
    // only on accept keeps later tx_data changes, and starts that arrive
    // while busy, from touching the byte in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg   <= tx_data;
            par_bit <= calc_parity(tx_data);
        end else if ((state == ST_DATA) && bit_end) begin
            shreg   <= {1'b0, shreg[7:1]};
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] tx_start;
    logic [2:0] tx;
    logic [2:0] tx_busy;
    logic [2:0] tx_done;
    logic [7:0] tx_data [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance i uses PARITY = i (0 none, 1 even, 2 odd); instance 2 also has 2 stop bits.
    uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
        .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
        .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_start(tx_start[2]),
        .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic push_exp(input int i, input logic [7:0] b);
        case (i)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    function automatic bit pop_exp(input int i, output logic [7:0] b);
        b = '0;
        case (i)
            0: if (q0.size() > 0) begin b = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin b = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin b = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int stops_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int frame_cycles(input int i);
        return CPB * (9 + ((i != 0) ? 1 : 0) + stops_of(i));
    endfunction

    // Reference: list of line bits for a byte, each expanded to CPB cycles.
    function automatic int expect_wave(input int i, input logic [7:0] b, output logic [63:0] w);
        int bits[$];
        int ones;
        int n;
        bits.push_back(0);
        for (int k = 0; k < 8; k++) bits.push_back(int'(b[k]));
        if (i != 0) begin
            ones = $countones(b);
            bits.push_back((i == 1) ? (ones % 2) : (1 - (ones % 2)));
        end
        for (int s = 0; s < stops_of(i); s++) bits.push_back(1);
        w = '0;
        n = 0;
        foreach (bits[j]) begin
            for (int c = 0; c < CPB; c++) begin
                w[n] = bits[j][0];
                n++;
            end
        end
        return n;
    endfunction

    // ---------------- monitor ----------------
    int          cyc [3];
    logic [63:0] wave [3];
    int          done_cnt [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 0; wave[i] = '0; done_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [7:0]  b;
            logic [63:0] w;
            int          n;
            if (!rst_n) begin
                cyc[i]  = 0;
                wave[i] = '0;
            end else begin
                if (tx_busy[i]) begin
                    if (cyc[i] < 64) wave[i][cyc[i]] = tx[i];
                    cyc[i]++;
                end else begin
                    chk($sformatf("idle_tx_high%0d", i), 64'(tx[i]), 64'd1);
                end
                if (tx_done[i]) begin
                    done_cnt[i]++;
                    if (pop_exp(i, b)) begin
                        n = expect_wave(i, b, w);
                        chk($sformatf("busy_len%0d_%02h", i, b), 64'(cyc[i]), 64'(n));
                        chk($sformatf("line_wave%0d_%02h", i, b), wave[i], w);
                        chk($sformatf("busy_at_done%0d", i), 64'(tx_busy[i]), 64'd0);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done%0d actual=done required=no_done", i);
                    end
                    cyc[i]  = 0;
                    wave[i] = '0;
                end else if (!tx_busy[i] && cyc[i] != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_fell_without_done%0d actual=%0d_cycles required=done", i, cyc[i]);
                    cyc[i]  = 0;
                    wave[i] = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int i);
        int g = 0;
        while (tx_busy[i] && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout%0d actual=busy required=idle", i);
        end
    endtask

    task automatic send(input int i, input logic [7:0] b);
        @(negedge clk);
        wait_idle(i);
        tx_data[i]  = b;
        tx_start[i] = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("busy_after_start%0d", i), 64'(tx_busy[i]), 64'd1);
        chk($sformatf("tx_low_after_start%0d", i), 64'(tx[i]), 64'd0);
        push_exp(i, b);
        tx_start[i] = 1'b0;
        tx_data[i]  = 8'($urandom);
    endtask

    logic [7:0] frame_bytes [7] = '{8'hAA, 8'h69, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h55};

    initial begin
        int d0;
        int i;
        rst_n    = 1'b0;
        tx_start = '0;
        for (int k = 0; k < 3; k++) tx_data[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_tx%0d", k), 64'(tx[k]), 64'd1);
            chk($sformatf("reset_busy%0d", k), 64'(tx_busy[k]), 64'd0);
            chk($sformatf("reset_done%0d", k), 64'(tx_done[k]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frames from the plan.
        send(0, 8'hAA); wait_idle(0);
        send(1, 8'h42); wait_idle(1);
        send(2, 8'h69); wait_idle(2);

        // Start while busy: 0x55 at cycle 10 is ignored.
        @(negedge clk);
        d0 = done_cnt[0];
        send(0, 8'hAA);
        repeat (9) @(posedge clk);
        @(negedge clk);
        tx_data[0]  = 8'h55;
        tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);
        chk("start_while_busy_done_count", 64'(done_cnt[0] - d0), 64'd1);

        // tx_start on the edge where busy falls is ignored.
        for (int k = 0; k < 3; k++) begin
            send(k, 8'($urandom));
            repeat (frame_cycles(k) - 1) @(posedge clk);
            @(negedge clk);
            tx_start[k] = 1'b1;
            tx_data[k]  = 8'hC3;
            @(posedge clk);
            #1;
            chk($sformatf("end_edge_busy%0d", k), 64'(tx_busy[k]), 64'd0);
            chk($sformatf("end_edge_done%0d", k), 64'(tx_done[k]), 64'd1);
            tx_start[k] = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            chk($sformatf("end_edge_no_restart%0d", k), 64'(tx_busy[k]), 64'd0);
        end

        // Reset mid-frame.
        send(1, 8'($urandom));
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", 64'(tx[1]), 64'd1);
        chk("midreset_busy", 64'(tx_busy[1]), 64'd0);
        chk("midreset_done", 64'(tx_done[1]), 64'd0);
        q0.delete(); q1.delete(); q2.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1, 8'hA5); wait_idle(1);

        // Frame-buffer byte sequence, back to back.
        @(negedge clk);
        d0 = done_cnt[0];
        for (int k = 0; k < 7; k++) send(0, frame_bytes[k]);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("frame7_done_count", 64'(done_cnt[0] - d0), 64'd7);

        // Random traffic with ignored starts poked in while busy.
        for (int r = 0; r < 36; r++) begin
            i = int'($urandom_range(0, 2));
            send(i, 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                tx_data[i]  = 8'($urandom);
                tx_start[i] = 1'b1;
                @(negedge clk);
                tx_start[i] = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) wait_idle(i);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) wait_idle(k);
        repeat (4) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Byte-serialising UART transmitter, directly downstream of the PID frame buffer. It accepts one byte per `tx_start` pulse and drives it onto the serial line as start bit, 8 data bits (LSB first), optional parity bit and 1 or 2 stop bits. It reports progress on `tx_busy`, which the frame buffer uses to pace its 7-byte frames.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud); legal range ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to transmit; sampled only when a start is accepted.
- `tx_start`  in  1  single-cycle request to send `tx_data`.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high from the cycle after start acceptance until the last stop bit completes.
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx` = 1, `tx_busy` = 0.
  - On `tx_start` = 1, latch `tx_data` into the shift register, compute the parity bit, clear the bit-clock counter and the bit index, and go to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0, held for `CLKS_PER_BIT` cycles.
  - Then shift right and increment the 3-bit index.
  - After index 7, go to PARITY if `PARITY` ≠ 0, else to STOP.
- PARITY:
  - `tx` = XOR of the latched byte for even parity, or its inverse for odd.
  - Held for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP:
  - `tx` = 1 for `CLKS_PER_BIT` × `STOP_BITS` cycles.
  - Then go to IDLE and pulse `tx_done`.
- Bit-clock counter:
  - Width `$clog2(CLKS_PER_BIT)`; counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
  - Never runs in IDLE.
- Stop-bit counter: 1 bit, used only when `STOP_BITS` = 2.
- `tx_start` while not IDLE: ignored. It is neither queued nor allowed to corrupt the latched byte.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- `tx`, `tx_busy` and `tx_done` are all registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values: `tx` = 1, `tx_busy` = 0, `tx_done` = 0, state = IDLE, counters = 0.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronously) and the frame is aborted. No `tx_done` is issued.
- Start acceptance and busy assertion: `tx_start` is sampled high in IDLE at edge N. After edge N, `tx` = 0 and `tx_busy` = 1. Upstream therefore sees busy exactly one cycle after its start pulse.
- Busy duration: `tx_busy` stays high for exactly `CLKS_PER_BIT` × (9 + (`PARITY` ≠ 0) + `STOP_BITS`) cycles.
- Frame end: on the edge that ends the last stop bit, `tx_busy` → 0 and `tx_done` → 1 for one cycle. `tx` remains 1.
- Back-to-back frames: a `tx_start` in the first IDLE cycle is accepted on that edge. The minimum inter-frame gap is therefore 1 cycle of idle plus the stop bits.
- Simultaneous events: `tx_start` on the edge where busy falls is ignored, because the state is not yet IDLE.

## Test plan
- Use `CLKS_PER_BIT` = 4 for all scenarios.
- **0xAA, no parity, 1 stop bit:** reset, then pulse `tx_start` with `tx_data` = 0xAA.
  - `tx` bit sequence = 0,0,1,0,1,0,1,0,1,1, each held 4 cycles.
  - `tx_busy` high 40 cycles; `tx_done` pulses once at cycle 41.
- **Even parity:** `PARITY` = 1, send 0x42.
  - Parity bit = 0.
  - Busy lasts 44 cycles.
- **Odd parity, 2 stop bits:** `PARITY` = 2, `STOP_BITS` = 2, send 0x69.
  - Parity bit = 1.
  - Stop high for 8 cycles.
  - Busy lasts 48 cycles.
- **Start while busy:** pulse `tx_start` with 0x55 at cycle 10 of a 0xAA frame.
  - 0xAA completes unchanged; no second frame.
  - `tx_done` pulses exactly once.
- **Reset mid-frame:** drive `rst_n` low at cycle 15 of a frame.
  - `tx` = 1 and `tx_busy` = 0 within the same cycle; no `tx_done`.
  - The next `tx_start` after release sends a clean frame.
- **Integration with the frame buffer:** drive 0x3F800000 with test = 0.
  - Decoded line bytes = AA, 69, 00, 00, 80, 3F, 55.
  - Exactly 7 `tx_done` pulses.
